// File: rtl/trap_ctrl.sv
// ----------------------------------------------------------------------------
// trap_ctrl
//   Machine-mode trap controller for the execute stage. Arbitrates synchronous
//   exceptions (illegal, ecall, ebreak) and NUM_IRQ level interrupt lines with
//   fixed priority. Sequences the mcause/mstatus/mepc/mtval writes over one CSR
//   write port, then redirects the pipeline to a direct or vectored mtvec
//   target. Also handles mret with the MPIE/MIE restore.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   inst_valid_i               execute-stage instruction valid (gates requests)
//   inst_addr_i, inst_i        PC and instruction word in execute
//   illegal_inst_i, inst_ecall_i, inst_ebreak_i, inst_mret_i   decode flags
//   mtvec_i, mepc_i, mstatus_i current CSR values
//   irq_i, irq_en_i            interrupt lines (level) and per-line enables
//   csr_we_o/waddr_o/wdata_o   CSR write port
//   stall_flag_o               pipeline hold
//   int_assert_o, int_addr_o   one-cycle redirect strobe and target
//   irq_ack_o                  one-hot acknowledge of the accepted line
// ----------------------------------------------------------------------------
module trap_ctrl #(
  parameter int NUM_IRQ        = 8,
  parameter int IRQ_CAUSE_BASE = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               inst_valid_i,
  input  logic [31:0]        inst_addr_i,
  input  logic [31:0]        inst_i,
  input  logic               illegal_inst_i,
  input  logic               inst_ecall_i,
  input  logic               inst_ebreak_i,
  input  logic               inst_mret_i,
  input  logic [31:0]        mtvec_i,
  input  logic [31:0]        mepc_i,
  input  logic [31:0]        mstatus_i,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic [NUM_IRQ-1:0] irq_en_i,
  output logic               csr_we_o,
  output logic [31:0]        csr_waddr_o,
  output logic [31:0]        csr_wdata_o,
  output logic               stall_flag_o,
  output logic               int_assert_o,
  output logic [31:0]        int_addr_o,
  output logic [NUM_IRQ-1:0] irq_ack_o
);

  localparam int IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

  localparam logic [31:0] CSR_MSTATUS = 32'h0000_0300;
  localparam logic [31:0] CSR_MEPC    = 32'h0000_0341;
  localparam logic [31:0] CSR_MCAUSE  = 32'h0000_0342;
  localparam logic [31:0] CSR_MTVAL   = 32'h0000_0343;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MSTATUS,
    S_W_MEPC,
    S_W_MTVAL,
    S_ASSERT
  } state_t;

  state_t state_q, state_d;

  logic [31:0] target_q;
  logic [31:0] pc_q;
  logic [31:0] mtval_q;

  // Request decode
  logic [NUM_IRQ-1:0] irq_pend;
  logic               irq_hit;
  logic [IDX_W-1:0]   irq_idx;
  logic               exc_take;
  logic               irq_take;
  logic               trap_take;
  logic               mret_take;
  logic [31:0]        irq_cause_num;
  logic [31:0]        trap_cause;
  logic [31:0]        trap_mtval;
  logic [31:0]        mtvec_base;
  logic [31:0]        trap_target;
  logic [31:0]        mstatus_trap;
  logic [31:0]        mstatus_mret;

  // Lowest-index pending line wins: scan from the top so the last hit is lowest.
  always_comb begin
    irq_pend = irq_i & irq_en_i;
    irq_hit  = 1'b0;
    irq_idx  = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (irq_pend[i]) begin
        irq_hit = 1'b1;
        irq_idx = IDX_W'(i);
      end
    end
  end

  always_comb begin
    exc_take  = inst_valid_i & (illegal_inst_i | inst_ecall_i | inst_ebreak_i);
    irq_take  = inst_valid_i & mstatus_i[3] & irq_hit & ~exc_take;
    trap_take = exc_take | irq_take;
    mret_take = inst_valid_i & inst_mret_i & ~trap_take;

    irq_cause_num = 32'(IRQ_CAUSE_BASE) + 32'(irq_idx);
    mtvec_base    = {mtvec_i[31:2], 2'b00};

    if (illegal_inst_i) begin
      trap_cause = 32'd2;
      trap_mtval = inst_i;
    end else if (inst_ecall_i) begin
      trap_cause = 32'd11;
      trap_mtval = 32'd0;
    end else if (inst_ebreak_i) begin
      trap_cause = 32'd3;
      trap_mtval = inst_addr_i;
    end else begin
      trap_cause = irq_cause_num | 32'h8000_0000;
      trap_mtval = 32'd0;
    end

    // Vectoring applies to interrupts only; exceptions always use the base.
    if (irq_take && (mtvec_i[1:0] == 2'b01))
      trap_target = mtvec_base + (irq_cause_num << 2);
    else
      trap_target = mtvec_base;

    mstatus_trap    = mstatus_i;
    mstatus_trap[7] = mstatus_i[3];
    mstatus_trap[3] = 1'b0;

    mstatus_mret    = mstatus_i;
    mstatus_mret[3] = mstatus_i[7];
    mstatus_mret[7] = 1'b1;
  end

  // State register and accept-time latches
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      target_q <= 32'd0;
      pc_q     <= 32'd0;
      mtval_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE) begin
        if (trap_take) begin
          target_q <= trap_target;
          pc_q     <= inst_addr_i;
          mtval_q  <= trap_mtval;
        end else if (mret_take) begin
          target_q <= mepc_i;
        end
      end
    end
  end

  // Next state and outputs
  always_comb begin
    state_d      = state_q;
    csr_we_o     = 1'b0;
    csr_waddr_o  = 32'd0;
    csr_wdata_o  = 32'd0;
    stall_flag_o = 1'b0;
    int_assert_o = 1'b0;
    int_addr_o   = 32'd0;
    irq_ack_o    = '0;

    case (state_q)
      S_IDLE: begin
        if (trap_take) begin
          csr_we_o     = 1'b1;
          csr_waddr_o  = CSR_MCAUSE;
          csr_wdata_o  = trap_cause;
          stall_flag_o = 1'b1;
          if (irq_take)
            irq_ack_o = NUM_IRQ'(1) << irq_idx;
          state_d = S_W_MSTATUS;
        end else if (mret_take) begin
          csr_we_o     = 1'b1;
          csr_waddr_o  = CSR_MSTATUS;
          csr_wdata_o  = mstatus_mret;
          stall_flag_o = 1'b1;
          state_d      = S_ASSERT;
        end
      end
      S_W_MSTATUS: begin
        csr_we_o     = 1'b1;
        csr_waddr_o  = CSR_MSTATUS;
        csr_wdata_o  = mstatus_trap;
        stall_flag_o = 1'b1;
        state_d      = S_W_MEPC;
      end
      S_W_MEPC: begin
        csr_we_o     = 1'b1;
        csr_waddr_o  = CSR_MEPC;
        csr_wdata_o  = pc_q;
        stall_flag_o = 1'b1;
        state_d      = S_W_MTVAL;
      end
      S_W_MTVAL: begin
        csr_we_o     = 1'b1;
        csr_waddr_o  = CSR_MTVAL;
        csr_wdata_o  = mtval_q;
        stall_flag_o = 1'b1;
        state_d      = S_ASSERT;
      end
      S_ASSERT: begin
        int_assert_o = 1'b1;
        int_addr_o   = target_q;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: doc/trap_ctrl.md
# trap_ctrl

Parametrised machine-mode trap controller for the core's execute stage. It arbitrates synchronous exceptions and `NUM_IRQ` level-sensitive interrupt lines with fixed priority, and sequences the mcause, mstatus, mepc and mtval CSR writes over a single CSR write port. It then redirects the pipeline to a direct or vectored mtvec target, and handles mret with MPIE/MIE restore. Debug-mode entry and exit are outside this block.

## Interface

**Parameters**
- `NUM_IRQ`, 8: number of interrupt lines, 1..32.
- `IRQ_CAUSE_BASE`, 16: mcause code of line 0; line i reports `IRQ_CAUSE_BASE+i`.

**Ports**
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `inst_valid_i` in 1: instruction in execute is valid. Gates every request.
- `inst_addr_i` in 32: PC of the instruction in execute.
- `inst_i` in 32: instruction word, used for mtval on illegal instruction.
- `illegal_inst_i`, `inst_ecall_i`, `inst_ebreak_i`, `inst_mret_i` in 1 each: decode flags.
- `mtvec_i`, `mepc_i`, `mstatus_i` in 32 each: current CSR values.
- `irq_i` in NUM_IRQ: interrupt lines, level, active-high.
- `irq_en_i` in NUM_IRQ: per-line enable (mie slice).
- `csr_we_o` out 1: CSR write strobe.
- `csr_waddr_o` out 32: CSR address, zero-extended 12-bit.
- `csr_wdata_o` out 32: CSR write data.
- `stall_flag_o` out 1: pipeline hold.
- `int_assert_o` out 1: one-cycle redirect strobe.
- `int_addr_o` out 32: redirect target.
- `irq_ack_o` out NUM_IRQ: one-hot, one-cycle acknowledge of the accepted line.

## Operation

**Request priority.** Evaluated only in IDLE, and only when `inst_valid_i`=1:
- illegal: cause 2, mtval = `inst_i`
- ecall: cause 11, mtval = 0
- ebreak: cause 3, mtval = `inst_addr_i`
- interrupt: `mstatus_i[3]` & |(`irq_i` & `irq_en_i`); lowest index wins; cause = {1'b1, `IRQ_CAUSE_BASE`+i}; mtval = 0
- mret

An exception always beats an interrupt and also beats mret.

**Target address, latched at accept.**
- `mtvec_i[1:0]`==01 and interrupt: {mtvec[31:2],2'b00} + 4·(`IRQ_CAUSE_BASE`+i), 32-bit wrap.
- Otherwise: {mtvec[31:2],2'b00}.
- mret: `mepc_i`.

**States:** IDLE, W_MSTATUS, W_MEPC, W_MTVAL, ASSERT.
- IDLE, trap accepted: write mcause (0x342) with the cause. Latch target, return PC = `inst_addr_i`, and mtval. Pulse `irq_ack_o` for an interrupt. Go to W_MSTATUS.
- W_MSTATUS: write mstatus (0x300) = `mstatus_i` with bit7 (MPIE) ← `mstatus_i[3]` and bit3 (MIE) ← 0. Go to W_MEPC.
- W_MEPC: write mepc (0x341) = latched PC. Go to W_MTVAL.
- W_MTVAL: write mtval (0x343) = latched value. Go to ASSERT.
- IDLE, mret: write mstatus with MIE ← `mstatus_i[7]` and MPIE ← 1. Latch `mepc_i`. Go to ASSERT.
- ASSERT: `int_assert_o`=1, `int_addr_o` = latched target, no CSR write. Go to IDLE. Requests are ignored in this state.
- `csr_we_o`=0 and `csr_waddr_o`/`csr_wdata_o`=0 in any state that does not write.

**stall_flag_o** = (state ∉ {IDLE, ASSERT}) | (state==IDLE & any qualified request, including mret).

## Timing

- **Reset values:** state IDLE, all latches 0. Outputs: `csr_we_o`=0, `csr_waddr_o`=0, `csr_wdata_o`=0, `stall_flag_o`=0, `int_assert_o`=0, `int_addr_o`=0, `irq_ack_o`=0.
- **Trap accepted at cycle T:**
  - mcause write at T
  - mstatus write at T+1
  - mepc write at T+2
  - mtval write at T+3
  - `int_assert_o` at T+4
  - IDLE at T+5
- **mret at T:** mstatus write at T, assert at T+1.
- **Late input changes:** `irq_i` deasserting, or `mtvec_i`/`inst_*` changing after T, does not alter the running sequence.
- **Interrupt blocking:** `mstatus_i[3]`=0 or `inst_valid_i`=0 blocks interrupts. Pending lines stay pending; there is no internal latching of `irq_i`.
- **Simultaneous events:**
  - exception + interrupt: exception taken, `irq_ack_o`=0.
  - exception + mret: exception taken.
  - two lines pending: lowest index taken first; the other is taken after the handler re-enables MIE.
- **Reset mid-sequence:** immediate IDLE; the remaining CSR writes and the assert are dropped.

## Test plan

- **Ecall:** `mtvec_i`=0x100, ecall at PC 0x80 → mcause=11 at T, mstatus MIE cleared at T+1, mepc=0x80 at T+2, mtval=0 at T+3, `int_addr_o`=0x100 at T+4, `stall_flag_o` high for T..T+3.
- **Vectored interrupt:** `mtvec_i`=0x201, `irq_i`=0b0110 all enabled, MIE=1 → line 1 taken, `irq_ack_o`=0b0010, mcause=0x80000011, target 0x244.
- **Illegal + interrupt:** illegal `inst_i`=0xFFFFFFFF at PC 0x40 with `irq_i[0]`=1 → mcause=2, mtval=0xFFFFFFFF, `irq_ack_o`=0, target = mtvec base.
- **Masking:** MIE=0, or `irq_en_i`=0, or `inst_valid_i`=0 with `irq_i`=all-ones → no CSR write, `stall_flag_o`=0.
- **mret:** `mstatus_i`=0x80, `mepc_i`=0x1234 → mstatus write 0x88 at T, `int_assert_o` with address 0x1234 at T+1.
- **Reset mid-sequence:** `rst_n` low at T+2 → all outputs 0 next edge; after release, no mepc/mtval writes and no assert occur.
